// File: rtl/fib_seq_gen.sv
// Fibonacci-class sequence generator with programmable seeds/term count and a valid/ready stream.
// Optional macro FIB_SAT_EN: the first overflowing term is emitted saturated and ends the run.
module fib_seq_gen #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] n_terms,
  output logic [WIDTH-1:0] term_out,
  output logic             term_valid,
  input  logic             term_ready,
  output logic [CNT_W-1:0] term_idx,
  output logic             term_last,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

`ifdef FIB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             a_carry_reg, a_carry_next;
  logic             b_carry_reg, b_carry_next;
  logic [CNT_W-1:0] n_reg, n_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic [WIDTH:0]   sum;
  logic             at_end;

  // The carry of each addition travels with the term it produced, so the
  // overflow flag fires exactly when that term reaches the output.
  assign sum    = {1'b0, a_reg} + {1'b0, b_reg};
  assign at_end = (cnt_reg == (n_reg - CNT_W'(1))) || (SAT_EN && a_carry_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      a_carry_reg <= 1'b0;
      b_carry_reg <= 1'b0;
      n_reg       <= '0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      a_carry_reg <= a_carry_next;
      b_carry_reg <= b_carry_next;
      n_reg       <= n_next;
      cnt_reg     <= cnt_next;
      ovf_reg     <= ovf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    a_carry_next = a_carry_reg;
    b_carry_next = b_carry_reg;
    n_next       = n_reg;
    cnt_next     = cnt_reg;
    ovf_next     = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          a_next       = seed0;
          b_next       = seed1;
          a_carry_next = 1'b0;
          b_carry_next = 1'b0;
          n_next       = n_terms;
          cnt_next     = '0;
          ovf_next     = 1'b0;
          state_next   = (n_terms == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (term_ready) begin
          if (at_end) begin
            state_next = DONE;
          end else begin
            a_next       = (SAT_EN && b_carry_reg) ? {WIDTH{1'b1}} : b_reg;
            a_carry_next = b_carry_reg;
            b_next       = sum[WIDTH-1:0];
            b_carry_next = sum[WIDTH];
            cnt_next     = cnt_reg + CNT_W'(1);
            if (b_carry_reg) begin
              ovf_next = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign term_out   = a_reg;
  assign term_idx   = cnt_reg;
  assign term_valid = (state_reg == RUN);
  assign term_last  = (state_reg == RUN) && at_end;
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);
  assign ovf        = ovf_reg;

endmodule
